crc_engine: RTL and testbench
=============================

# crc_engine

Parametrised, synchronous CRC generator/checker for the serial and byte-wide CRC paths of the core. It generalises the fixed single-bit CRC-7 register to any polynomial width, seed, output XOR, bit reflection and beat width. It adds frame control, a registered final result with a valid strobe, and a residue check for receive paths. It sits between a framing FSM (SD/I2C/packet) and the data path and consumes one beat per cycle with no back-pressure.

## Interface
- `CRC_W`, 7: CRC register width, 1..32
- `POLY`, 'h09: generator polynomial, CRC_W bits, implicit x^CRC_W term omitted (default = x^7+x^3+1)
- `INIT`, 0: register seed loaded at frame start
- `XOROUT`, 0: value XORed into the final result
- `DATA_W`, 1: bits per beat, 1..64
- `REFIN`, 0: 1 = each beat is consumed LSB-first; 0 = MSB-first
- `REFOUT`, 0: 1 = final register is bit-reversed before the XOROUT step
- `RESIDUE`, 0: raw register value that signals a good frame when the received CRC is included in the data

- `clk` in 1: clock, all logic on the rising edge
- `rst` in 1: reset; synchronous and active-high
- `start` in 1: opens a frame and seeds the register with INIT
- `din_valid` in 1: a data beat is present
- `din` in DATA_W: beat data
- `din_last` in 1: qualified by `din_valid`; marks the final beat of the frame
- `crc_o` out CRC_W: final CRC (after reflection and XOROUT), held until the next frame completes
- `crc_valid` out 1: one-cycle pulse, `crc_o` and `crc_ok` are new
- `crc_ok` out 1: raw register == RESIDUE at frame end; held with `crc_o`
- `busy` out 1: a frame is open
- `drop_o` out 1: one-cycle pulse, a beat arrived while no frame was open and was ignored

## Operation
- States: IDLE, RUN.
  - IDLE -> RUN on `start` without a same-cycle last beat.
  - RUN -> IDLE on an accepted beat with `din_last`.
  - RUN + `start`: abort the frame and reseed. No `crc_valid` is produced for the aborted frame.
- Bit step, applied to each bit d in beat order:
  - inv = d ^ r[CRC_W-1]
  - r = {r[CRC_W-2:0],0} ^ (inv ? POLY : 0)
- With CRC_W=7, POLY='h09 and DATA_W=1, the block is bit-exact with the legacy serial CRC-7 (reset seed 0).
- A beat applies DATA_W bit steps combinationally in one cycle. Bit order is `din[DATA_W-1]` first when REFIN=0, and `din[0]` first when REFIN=1.
- The seed for a beat is INIT if `start` is high in the same cycle, otherwise the current register. A `start` with a valid beat therefore processes that beat as the first beat of the new frame.
- A `start`+`din_valid`+`din_last` cycle is a complete single-beat frame.
- In IDLE, a `din_valid` without `start` is ignored, `drop_o`=1 for that cycle, and the register is unchanged.
- At frame end, the final value is computed from the register after the last beat:
  - f = REFOUT ? bitreverse(r) : r
  - `crc_o` <= f ^ XOROUT
  - `crc_ok` <= (r == RESIDUE), using the raw register
- `din_last` without `din_valid` has no effect.
- Reset values:
  - register = INIT
  - state = IDLE
  - `crc_o`=0, `crc_ok`=0, `crc_valid`=0, `busy`=0, `drop_o`=0
- Reset mid-frame discards the frame; no `crc_valid` follows.

## Timing
- Throughput is one beat per clock, with no stall input.
- `busy` rises the cycle after `start` and falls the cycle after the last beat.
- `crc_valid` asserts exactly 1 cycle after the clock edge that samples the last beat. `crc_o` and `crc_ok` update in the same cycle.
- A new `start` may coincide with that `crc_valid` cycle, giving back-to-back frames with zero idle cycles.
- The beat path is combinational XOR depth proportional to DATA_W. It must close timing at DATA_W=64 and CRC_W=32 for the core clock.

## Test plan
- CRC_W=7, POLY='h09, DATA_W=1: serial bits of 40 00 00 00 00 (MSB-first, 40 bits, `start` on the first bit) -> `crc_valid` one cycle after bit 40 with `crc_o`=7'h4A.
- CRC-16/CCITT-FALSE, i.e. CRC_W=16, POLY='h1021, INIT='hFFFF, DATA_W=8:
  - "123456789" -> `crc_o`=16'h29B1.
  - The same frame followed by bytes 29 B1 with RESIDUE=0 -> `crc_ok`=1.
  - Corrupting one data bit in that frame -> `crc_ok`=0.
- CRC-32 (POLY='h04C11DB7, INIT=XOROUT='hFFFFFFFF, REFIN=REFOUT=1, DATA_W=32): "123456789" sent as two 32-bit beats plus one 8-bit frame is not legal. Instead, with DATA_W=8, the 9 bytes -> `crc_o`=32'hCBF43926.
- Back-to-back and abort, using the CRC-16 setup:
  - Two frames with `start` coinciding with the previous `crc_valid` -> both results correct.
  - `start` mid-frame -> no `crc_valid` for the aborted frame, and the new frame's result is correct.
- Single-beat frame: a `start`+`din_valid`+`din_last` cycle -> `crc_valid` on the next cycle and the result equals the reference model.
- Beats in IDLE produce `drop_o` pulses with the register unchanged.
- Synchronous `rst` mid-frame returns all outputs to their reset values on the next edge.

Source files
------------

// File: rtl/crc_engine.sv
// Parametrised CRC generator/checker: one DATA_W-bit beat per clock, framed by
// start/din_last, with a registered final result, valid strobe and residue check.
module crc_engine #(
   parameter int               CRC_W   = 7,
   parameter logic [CRC_W-1:0] POLY    = CRC_W'('h09),
   parameter logic [CRC_W-1:0] INIT    = '0,
   parameter logic [CRC_W-1:0] XOROUT  = '0,
   parameter int               DATA_W  = 1,
   parameter bit               REFIN   = 1'b0,
   parameter bit               REFOUT  = 1'b0,
   parameter logic [CRC_W-1:0] RESIDUE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              din_valid,
   input  logic [DATA_W-1:0] din,
   input  logic              din_last,
   output logic [CRC_W-1:0]  crc_o,
   output logic              crc_valid,
   output logic              crc_ok,
   output logic              busy,
   output logic              drop_o,
   output logic              o_dbg_state
);

   // Handshake: a beat is consumed on every edge where din_valid is high and a
   // frame is open (or start opens one in the same cycle); there is no ready.

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t           r_state;
   logic [CRC_W-1:0] r_crc;
   logic [CRC_W-1:0] r_crc_o;
   logic             r_crc_ok;
   logic             r_crc_valid;
   logic             r_busy;
   logic             r_drop;

   logic [CRC_W-1:0] w_seed;
   logic [CRC_W-1:0] w_next;
   logic [CRC_W-1:0] w_result;

   function automatic logic [CRC_W-1:0] crc_beat(input logic [CRC_W-1:0] seed,
                                                 input logic [DATA_W-1:0] data);
      logic [CRC_W-1:0] r;
      logic             d;
      logic             inv;
      r = seed;
      for (int i = 0; i < DATA_W; i++) begin
         d   = REFIN ? data[i] : data[DATA_W-1-i];
         inv = d ^ r[CRC_W-1];
         r   = (r << 1) ^ (inv ? POLY : '0);
      end
      return r;
   endfunction

   function automatic logic [CRC_W-1:0] bit_rev(input logic [CRC_W-1:0] v);
      logic [CRC_W-1:0] o;
      o = '0;
      for (int i = 0; i < CRC_W; i++) begin
         o[i] = v[CRC_W-1-i];
      end
      return o;
   endfunction

   // A start in the same cycle as a beat makes that beat the first of the new frame.
   always_comb begin
      w_seed   = start ? INIT : r_crc;
      w_next   = crc_beat(w_seed, din);
      w_result = (REFOUT ? bit_rev(w_next) : w_next) ^ XOROUT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_crc       <= INIT;
         r_crc_o     <= '0;
         r_crc_ok    <= 1'b0;
         r_crc_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_drop      <= 1'b0;
      end else begin
         r_crc_valid <= 1'b0;
         r_drop      <= 1'b0;
         if (start) begin
            r_crc <= din_valid ? w_next : INIT;
            if (din_valid && din_last) begin
               r_crc_o     <= w_result;
               r_crc_ok    <= (w_next == RESIDUE);
               r_crc_valid <= 1'b1;
               r_state     <= ST_IDLE;
               r_busy      <= 1'b0;
            end else begin
               r_state <= ST_RUN;
               r_busy  <= 1'b1;
            end
         end else if (r_state == ST_RUN) begin
            if (din_valid) begin
               r_crc <= w_next;
               if (din_last) begin
                  r_crc_o     <= w_result;
                  r_crc_ok    <= (w_next == RESIDUE);
                  r_crc_valid <= 1'b1;
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
               end
            end
         end else if (din_valid) begin
            r_drop <= 1'b1;
         end
      end
   end

   assign crc_o       = r_crc_o;
   assign crc_ok      = r_crc_ok;
   assign crc_valid   = r_crc_valid;
   assign busy        = r_busy;
   assign drop_o      = r_drop;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: CRC-7 serial, CRC-16/CCITT-FALSE byte-wide and
// reflected CRC-32 instances, checked against known check values and a CRC-16 model.
module tb_crc_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // CRC-7 serial instance
   logic        s7 = 0, v7 = 0, l7 = 0;
   logic [0:0]  d7 = '0;
   logic [6:0]  c7;
   logic        cv7, ok7, b7, dr7, st7;

   // CRC-16/CCITT-FALSE instance, residue 0
   logic        s16 = 0, v16 = 0, l16 = 0;
   logic [7:0]  d16 = '0;
   logic [15:0] c16;
   logic        cv16, ok16, b16, dr16, st16;

   // CRC-32 reflected instance
   logic        s32 = 0, v32 = 0, l32 = 0;
   logic [7:0]  d32 = '0;
   logic [31:0] c32;
   logic        cv32, ok32, b32, dr32, st32;

   crc_engine #(.CRC_W(7), .POLY(7'h09), .INIT(7'h00), .XOROUT(7'h00), .DATA_W(1),
                .REFIN(1'b0), .REFOUT(1'b0), .RESIDUE(7'h00)) u7 (
      .clk(clk), .rst(rst), .start(s7), .din_valid(v7), .din(d7), .din_last(l7),
      .crc_o(c7), .crc_valid(cv7), .crc_ok(ok7), .busy(b7), .drop_o(dr7),
      .o_dbg_state(st7));

   crc_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOROUT(16'h0000),
                .DATA_W(8), .REFIN(1'b0), .REFOUT(1'b0), .RESIDUE(16'h0000)) u16 (
      .clk(clk), .rst(rst), .start(s16), .din_valid(v16), .din(d16), .din_last(l16),
      .crc_o(c16), .crc_valid(cv16), .crc_ok(ok16), .busy(b16), .drop_o(dr16),
      .o_dbg_state(st16));

   crc_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                .XOROUT(32'hFFFFFFFF), .DATA_W(8), .REFIN(1'b1), .REFOUT(1'b1),
                .RESIDUE(32'h00000000)) u32 (
      .clk(clk), .rst(rst), .start(s32), .din_valid(v32), .din(d32), .din_last(l32),
      .crc_o(c32), .crc_valid(cv32), .crc_ok(ok32), .busy(b32), .drop_o(dr32),
      .o_dbg_state(st32));

   logic [15:0] exp_q[$];
   logic [7:0]  msg [0:15];
   int          vcnt16 = 0;

   always @(negedge clk) begin
      if (cv16 === 1'b1) vcnt16++;
   end

   // ---------------- driver tasks ----------------
   task automatic drive7(input logic s, input logic v, input logic l, input logic d);
      s7 = s; v7 = v; l7 = l; d7 = d;
      @(posedge clk); #1;
   endtask

   task automatic drive16(input logic s, input logic v, input logic l, input logic [7:0] d);
      s16 = s; v16 = v; l16 = l; d16 = d;
      @(posedge clk); #1;
   endtask

   task automatic drive32(input logic s, input logic v, input logic l, input logic [7:0] d);
      s32 = s; v32 = v; l32 = l; d32 = d;
      @(posedge clk); #1;
   endtask

   task automatic send16(input logic [7:0] b [0:15], input int n);
      for (int i = 0; i < n; i++) drive16(i == 0, 1'b1, i == n - 1, b[i]);
   endtask

   // Textbook MSB-first CCITT formulation: fold the byte into the top, then shift.
   function automatic logic [15:0] crc16_model(input logic [7:0] b [0:15], input int n);
      logic [15:0] crc;
      crc = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         crc = crc ^ {b[i], 8'h00};
         for (int k = 0; k < 8; k++) crc = crc[15] ? ((crc << 1) ^ 16'h1021) : (crc << 1);
      end
      return crc;
   endfunction

   task automatic check_result16(input string name);
      logic [15:0] exp;
      checks++;
      if (cv16 !== 1'b1) begin
         errors++;
         $display("FAIL %s_valid got %b exp 1", name, cv16);
      end
      exp = exp_q.pop_front();
      checks++;
      if (c16 !== exp) begin
         errors++;
         $display("FAIL %s_crc got %h exp %h", name, c16, exp);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({c7, cv7, ok7, b7, dr7} !== 11'b0) begin
         errors++; $display("FAIL reset_u7 got %h exp 0", {c7, cv7, ok7, b7, dr7});
      end
      checks++;
      if ({c16, cv16, ok16, b16, dr16} !== 20'b0) begin
         errors++; $display("FAIL reset_u16 got %h exp 0", {c16, cv16, ok16, b16, dr16});
      end
      checks++;
      if ({c32, cv32, ok32, b32, dr32} !== 36'b0) begin
         errors++; $display("FAIL reset_u32 got %h exp 0", {c32, cv32, ok32, b32, dr32});
      end
      rst = 1'b0;
   endtask

   task automatic test_crc7_serial();
      logic [39:0] bits;
      bits = 40'h40_0000_0000;
      for (int i = 0; i < 40; i++) begin
         drive7(i == 0, 1'b1, i == 39, bits[39-i]);
         if (i == 0) begin
            checks++;
            if (b7 !== 1'b1) begin errors++; $display("FAIL crc7_busy_rise got %b exp 1", b7); end
         end
      end
      checks++;
      if (cv7 !== 1'b1) begin errors++; $display("FAIL crc7_valid got %b exp 1", cv7); end
      checks++;
      if (c7 !== 7'h4A) begin errors++; $display("FAIL crc7_value got %h exp 4a", c7); end
      checks++;
      if (ok7 !== 1'b0) begin errors++; $display("FAIL crc7_ok got %b exp 0", ok7); end
      checks++;
      if (b7 !== 1'b0) begin errors++; $display("FAIL crc7_busy_fall got %b exp 0", b7); end
      drive7(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({cv7, c7} !== {1'b0, 7'h4A}) begin
         errors++; $display("FAIL crc7_pulse_hold got %h exp 04a", {cv7, c7});
      end
   endtask

   task automatic test_crc16_check();
      exp_q.push_back(16'h29B1);
      send16(msg, 9);
      check_result16("crc16_check");
      checks++;
      if (ok16 !== 1'b0) begin errors++; $display("FAIL crc16_check_ok got %b exp 0", ok16); end
      drive16(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_residue();
      logic [7:0] b [0:15];
      b = msg;
      b[9]  = 8'h29;
      b[10] = 8'hB1;
      send16(b, 11);
      checks++;
      if ({ok16, c16} !== {1'b1, 16'h0000}) begin
         errors++; $display("FAIL residue_good got %h exp 10000", {ok16, c16});
      end
      drive16(1'b0, 1'b0, 1'b0, 8'h00);
      b[3] = b[3] ^ 8'h04;
      send16(b, 11);
      checks++;
      if ({cv16, ok16} !== 2'b10) begin
         errors++; $display("FAIL residue_bad got %b exp 10", {cv16, ok16});
      end
      drive16(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_crc32();
      for (int i = 0; i < 9; i++) drive32(i == 0, 1'b1, i == 8, msg[i]);
      checks++;
      if (cv32 !== 1'b1) begin errors++; $display("FAIL crc32_valid got %b exp 1", cv32); end
      checks++;
      if (c32 !== 32'hCBF43926) begin
         errors++; $display("FAIL crc32_value got %h exp cbf43926", c32);
      end
      drive32(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_back_to_back();
      logic [7:0] b [0:15];
      b = msg;
      b[0] = 8'h41; b[1] = 8'h42; b[2] = 8'h43;
      exp_q.push_back(16'h29B1);
      exp_q.push_back(crc16_model(b, 3));
      send16(msg, 9);
      check_result16("b2b_first");
      send16(b, 3);
      check_result16("b2b_second");
      drive16(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_abort();
      int n0;
      n0 = vcnt16;
      drive16(1'b1, 1'b1, 1'b0, 8'h55);
      drive16(1'b0, 1'b1, 1'b0, 8'hAA);
      drive16(1'b0, 0, 1'b1, 8'hFF);
      checks++;
      if ({cv16, b16} !== 2'b01) begin
         errors++; $display("FAIL abort_last_no_valid got %b exp 01", {cv16, b16});
      end
      exp_q.push_back(16'h29B1);
      send16(msg, 9);
      check_result16("abort_new");
      drive16(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (vcnt16 - n0 !== 1) begin
         errors++; $display("FAIL abort_valid_count got %0d exp 1", vcnt16 - n0);
      end
   endtask

   task automatic test_single_beat();
      logic [7:0] b [0:15];
      b = msg;
      b[0] = 8'h00;
      exp_q.push_back(crc16_model(b, 1));
      drive16(1'b1, 1'b1, 1'b1, 8'h00);
      check_result16("single");
      checks++;
      if (b16 !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", b16); end
      drive16(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_drop();
      logic [15:0] held;
      logic [7:0]  b [0:15];
      b = msg;
      b[0] = 8'h00;
      held = crc16_model(b, 1);
      for (int i = 0; i < 3; i++) begin
         drive16(1'b0, 1'b1, i == 2, 8'($urandom_range(0, 255)));
         checks++;
         if ({dr16, cv16, b16, c16} !== {3'b100, held}) begin
            errors++; $display("FAIL drop_beat%0d got %h exp %h", i, {dr16, cv16, b16, c16}, {3'b100, held});
         end
      end
      drive16(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (dr16 !== 1'b0) begin errors++; $display("FAIL drop_fall got %b exp 0", dr16); end
   endtask

   task automatic test_rst_mid_frame();
      int n0;
      drive16(1'b1, 1'b1, 1'b0, 8'h31);
      drive16(1'b0, 1'b1, 1'b0, 8'h32);
      checks++;
      if (b16 !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b exp 1", b16); end
      n0 = vcnt16;
      rst = 1'b1;
      drive16(1'b0, 1'b1, 1'b0, 8'h33);
      checks++;
      if ({c16, cv16, ok16, b16, dr16} !== 20'b0) begin
         errors++; $display("FAIL rst_mid_outputs got %h exp 0", {c16, cv16, ok16, b16, dr16});
      end
      rst = 1'b0;
      drive16(1'b0, 1'b1, 1'b1, 8'h34);
      checks++;
      if ({dr16, cv16} !== 2'b10) begin
         errors++; $display("FAIL rst_post_last got %b exp 10", {dr16, cv16});
      end
      drive16(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (vcnt16 !== n0) begin
         errors++; $display("FAIL rst_no_valid got %0d exp %0d", vcnt16, n0);
      end
   endtask

   initial begin
      msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      test_reset();
      test_crc7_serial();
      test_crc16_check();
      test_residue();
      test_crc32();
      test_back_to_back();
      test_abort();
      test_single_beat();
      test_drop();
      test_rst_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
